// File: rtl/match_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : match_timer_pkg
// Brief   : State encoding shared by the match_timer search FSM.
// Revision: 1.0
// ============================================================================
package match_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/match_timer_streak.sv
`default_nettype none
// ============================================================================
// Module  : streak_counter
// Brief   : Counts consecutive equal samples; flags the sample completing a run.
// Revision: 1.0
// ============================================================================
module streak_counter #(
    parameter int MATCH_RUN = 1,
    parameter int SW        = $clog2(MATCH_RUN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    input  logic          eq,
    output logic [SW-1:0] streak,
    output logic          reached
);

    localparam logic [SW:0]   c_run_w = (SW + 1)'(MATCH_RUN);
    localparam logic [SW-1:0] c_run   = SW'(MATCH_RUN);

    logic [SW-1:0] r_streak;
    logic [SW:0]   w_inc;

    assign w_inc   = {1'b0, r_streak} + 1'b1;
    assign reached = eq && (w_inc == c_run_w);
    assign streak  = r_streak;

    // Saturate at MATCH_RUN so the count stays bounded once a run completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
        end else if (clr) begin
            r_streak <= '0;
        end else if (en) begin
            if (!eq)
                r_streak <= '0;
            else if (r_streak != c_run)
                r_streak <= w_inc[SW-1:0];
        end
    end

endmodule
`default_nettype wire

// File: rtl/match_timer.sv
`default_nettype none
// ============================================================================
// Module  : match_timer
// Brief   : Watches a registered value for a held match or a cycle timeout.
// Revision: 1.0
// ============================================================================
module match_timer
    import match_timer_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int CNT_W     = 16,
    parameter int MATCH_RUN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CNT_W-1:0] timeout,
    output logic             busy,
    output logic             hit,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycles,
    output logic             done
);

    localparam int            SW    = $clog2(MATCH_RUN + 1);
    localparam logic [SW-1:0] c_run = SW'(MATCH_RUN);

    state_t           r_state, w_state_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_hit, w_hit_nxt;
    logic             r_timed_out, w_timed_out_nxt;
    logic [CNT_W-1:0] r_cycles, w_cycles_nxt;
    logic             r_done, w_done_nxt;
    logic             w_clr;
    logic             w_en;
    logic             w_eq;
    logic             w_reached;
    logic [SW-1:0]    w_streak;
    logic [CNT_W:0]   w_cyc_inc;
    logic [CNT_W-1:0] w_cyc_sat;
    logic             w_tmo;

    assign w_eq      = (data_in == target);
    assign w_en      = (r_state == S_RUN);
    assign w_cyc_inc = {1'b0, r_cycles} + 1'b1;
    assign w_cyc_sat = w_cyc_inc[CNT_W] ? r_cycles : w_cyc_inc[CNT_W-1:0];
    // Compare against the unsaturated count so a full-scale timeout still fires.
    assign w_tmo     = (timeout != '0) && (w_cyc_inc >= {1'b0, timeout});

    streak_counter #(
        .MATCH_RUN (MATCH_RUN),
        .SW        (SW)
    ) u_streak (
        .clk     (clk),
        .rst     (rst),
        .clr     (w_clr),
        .en      (w_en),
        .eq      (w_eq),
        .streak  (w_streak),
        .reached (w_reached)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_hit       <= 1'b0;
            r_timed_out <= 1'b0;
            r_cycles    <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= w_busy_nxt;
            r_hit       <= w_hit_nxt;
            r_timed_out <= w_timed_out_nxt;
            r_cycles    <= w_cycles_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_busy_nxt      = r_busy;
        w_hit_nxt       = r_hit;
        w_timed_out_nxt = r_timed_out;
        w_cycles_nxt    = r_cycles;
        w_done_nxt      = 1'b0;
        w_clr           = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt     = S_RUN;
                    w_busy_nxt      = 1'b1;
                    w_hit_nxt       = 1'b0;
                    w_timed_out_nxt = 1'b0;
                    w_cycles_nxt    = '0;
                    w_clr           = 1'b1;
                end
            end
            S_RUN: begin
                w_cycles_nxt = w_cyc_sat;
                // A match on the final allowed sample takes priority over timeout.
                if (w_reached) begin
                    w_state_nxt = S_DONE;
                    w_busy_nxt  = 1'b0;
                    w_hit_nxt   = 1'b1;
                    w_done_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt     = S_DONE;
                    w_busy_nxt      = 1'b0;
                    w_timed_out_nxt = 1'b1;
                    w_done_nxt      = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    a_streak_bound: assert property (@(posedge clk) disable iff (!rst) w_streak <= c_run);

    assign busy      = r_busy;
    assign hit       = r_hit;
    assign timed_out = r_timed_out;
    assign cycles    = r_cycles;
    assign done      = r_done;

endmodule
`default_nettype wire
